// File: rtl/gfx_cuvz_arb_pkg.sv
// Shared definitions for the colour/UV/Z interpolator arbiter.
//   - arb_state_t : FSM encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3)
//   - FLD_*       : payload field positions inside one requester slice,
//                   counted in units of point_width (factor0 in the LSBs)
//   - field_lsb() : converts a field position into a bit offset
package gfx_cuvz_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam int FLD_FACTOR0 = 0;
  localparam int FLD_FACTOR1 = 1;
  localparam int FLD_X       = 2;
  localparam int FLD_Y       = 3;
  localparam int FLD_COUNT   = 4;

  function automatic int field_lsb(input int fld, input int pw);
    return fld * pw;
  endfunction

endpackage

// File: rtl/gfx_rr_pick.sv
// Combinational round-robin selector.
// Scans req starting at rr_ptr, wrapping modulo NUM_REQ, and reports the
// first set bit.
//   req    in  NUM_REQ  request vector
//   rr_ptr in  2        index holding highest priority (must be < NUM_REQ)
//   valid  out 1        at least one request is set
//   index  out 2        index of the selected request (0 when !valid)
module gfx_rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         rr_ptr,
  output logic               valid,
  output logic [1:0]         index
);

  int cand;

  // Walk from the lowest priority position down to rr_ptr so that the
  // last hit, which is kept, is the highest priority one.
  always_comb begin
    valid = 1'b0;
    index = 2'd0;
    cand  = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req[cand]) begin
        valid = 1'b1;
        index = 2'(cand);
      end
    end
  end

endmodule

// File: rtl/gfx_cuvz_arbiter.sv
// Round-robin arbiter sharing one colour/UV/Z interpolator between
// NUM_REQ pixel producers. A level-held request is granted, its payload
// latched, a one-cycle write strobe issued, and after the interpolator's
// ack a one-cycle ack is returned to the winner.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_write_i  [NUM_REQ]  per-requester request, held until its ack
//   req_data_i              per-requester {y, x, factor1, factor0}
//   req_ack_o    [NUM_REQ]  one-cycle completion pulse to the winner
//   cuvz_write_o            one-cycle write strobe to the interpolator
//   cuvz_ack_i              interpolator completion pulse
//   cuvz_x/y/factor0/factor1_o  latched winner payload
//   grant_id_o   [2]        current or last winner
//   busy_o                  high outside IDLE
//
// Optional macro GFX_CUVZ_ARB_STATS_EN adds:
//   grant_count_o [NUM_REQ*32]  per-requester completed grants (wrapping)
//   stall_count_o [32]          WAIT cycles seen (saturating)
module gfx_cuvz_arbiter
  import gfx_cuvz_arb_pkg::*;
#(
  parameter int point_width = 16,
  parameter int NUM_REQ     = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_write_i,
  input  logic [NUM_REQ*4*point_width-1:0] req_data_i,
  output logic [NUM_REQ-1:0]             req_ack_o,
  output logic                           cuvz_write_o,
  input  logic                           cuvz_ack_i,
  output logic [point_width-1:0]         cuvz_x_o,
  output logic [point_width-1:0]         cuvz_y_o,
  output logic [point_width-1:0]         cuvz_factor0_o,
  output logic [point_width-1:0]         cuvz_factor1_o,
  output logic [1:0]                     grant_id_o,
  output logic                           busy_o
`ifdef GFX_CUVZ_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]          grant_count_o,
  output logic [31:0]                    stall_count_o
`endif
);

  localparam int SLICE_W  = FLD_COUNT * point_width;
  localparam int F0_LSB   = field_lsb(FLD_FACTOR0, point_width);
  localparam int F1_LSB   = field_lsb(FLD_FACTOR1, point_width);
  localparam int X_LSB    = field_lsb(FLD_X, point_width);
  localparam int Y_LSB    = field_lsb(FLD_Y, point_width);

  arb_state_t             state, state_nxt;
  logic [1:0]             rr_ptr, rr_ptr_nxt;
  logic                   pick_vld;
  logic [1:0]             pick_idx;
  logic [SLICE_W-1:0]     pick_slice;

  logic [1:0]             grant_nxt;
  logic [point_width-1:0] x_nxt, y_nxt, f0_nxt, f1_nxt;
  logic                   write_nxt, busy_nxt;
  logic [NUM_REQ-1:0]     ack_nxt;

  gfx_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req_write_i),
    .rr_ptr (rr_ptr),
    .valid  (pick_vld),
    .index  (pick_idx)
  );

  assign pick_slice = req_data_i[int'(pick_idx)*SLICE_W +: SLICE_W];

  // Next-state and next-output logic; every output is a register whose
  // next value is derived from the next state so outputs align with state.
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant_id_o;
    x_nxt      = cuvz_x_o;
    y_nxt      = cuvz_y_o;
    f0_nxt     = cuvz_factor0_o;
    f1_nxt     = cuvz_factor1_o;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          state_nxt = ST_ISSUE;
          grant_nxt = pick_idx;
          x_nxt     = pick_slice[X_LSB  +: point_width];
          y_nxt     = pick_slice[Y_LSB  +: point_width];
          f0_nxt    = pick_slice[F0_LSB +: point_width];
          f1_nxt    = pick_slice[F1_LSB +: point_width];
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        // Only an ack seen here completes a transaction.
        if (cuvz_ack_i) begin
          state_nxt  = ST_DONE;
          rr_ptr_nxt = (int'(grant_id_o) == NUM_REQ - 1) ? 2'd0
                                                          : grant_id_o + 2'd1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    write_nxt = (state_nxt == ST_ISSUE);
    busy_nxt  = (state_nxt != ST_IDLE);
    ack_nxt   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      ack_nxt[k] = (state_nxt == ST_DONE) && (int'(grant_nxt) == k);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= ST_IDLE;
      rr_ptr         <= 2'd0;
      grant_id_o     <= 2'd0;
      cuvz_x_o       <= '0;
      cuvz_y_o       <= '0;
      cuvz_factor0_o <= '0;
      cuvz_factor1_o <= '0;
      cuvz_write_o   <= 1'b0;
      req_ack_o      <= '0;
      busy_o         <= 1'b0;
    end else begin
      state          <= state_nxt;
      rr_ptr         <= rr_ptr_nxt;
      grant_id_o     <= grant_nxt;
      cuvz_x_o       <= x_nxt;
      cuvz_y_o       <= y_nxt;
      cuvz_factor0_o <= f0_nxt;
      cuvz_factor1_o <= f1_nxt;
      cuvz_write_o   <= write_nxt;
      req_ack_o      <= ack_nxt;
      busy_o         <= busy_nxt;
    end
  end

`ifdef GFX_CUVZ_ARB_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_count_o <= '0;
      stall_count_o <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (state == ST_DONE && int'(grant_id_o) == k)
          grant_count_o[k*32 +: 32] <= grant_count_o[k*32 +: 32] + 32'd1;
      end
      if (state == ST_WAIT && stall_count_o != 32'hFFFF_FFFF)
        stall_count_o <= stall_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gfx_cuvz_arbiter.sv
// Directed bench for gfx_cuvz_arbiter (point_width=16, NUM_REQ=2).
module tb_gfx_cuvz_arbiter;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [1:0]   req_write_i;
  logic [127:0] req_data_i;
  logic [1:0]   req_ack_o;
  logic         cuvz_write_o;
  logic         cuvz_ack_i;
  logic [15:0]  cuvz_x_o, cuvz_y_o, cuvz_factor0_o, cuvz_factor1_o;
  logic [1:0]   grant_id_o;
  logic         busy_o;
`ifdef GFX_CUVZ_ARB_STATS_EN
  logic [63:0]  grant_count_o;
  logic [31:0]  stall_count_o;
`endif

  int tests = 0;
  int fails = 0;

  gfx_cuvz_arbiter #(.point_width(16), .NUM_REQ(2)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_write_i    (req_write_i),
    .req_data_i     (req_data_i),
    .req_ack_o      (req_ack_o),
    .cuvz_write_o   (cuvz_write_o),
    .cuvz_ack_i     (cuvz_ack_i),
    .cuvz_x_o       (cuvz_x_o),
    .cuvz_y_o       (cuvz_y_o),
    .cuvz_factor0_o (cuvz_factor0_o),
    .cuvz_factor1_o (cuvz_factor1_o),
    .grant_id_o     (grant_id_o),
    .busy_o         (busy_o)
`ifdef GFX_CUVZ_ARB_STATS_EN
    ,
    .grant_count_o  (grant_count_o),
    .stall_count_o  (stall_count_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [15:0] y, input logic [15:0] x,
                                       input logic [15:0] f1, input logic [15:0] f0);
    return {y, x, f1, f0};
  endfunction

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // Waits (bounded) for a write strobe, checks the winner, acks after lat
  // WAIT cycles, and checks the returned ack. Returns in the DONE cycle.
  task automatic serve(input int exp_id, input int lat, input logic [15:0] exp_x);
    int n;
    n = 0;
    while (cuvz_write_o !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    chk("write_seen", {63'd0, cuvz_write_o}, 64'd1);
    if (cuvz_write_o !== 1'b1) return;
    chk("grant_id", {62'd0, grant_id_o}, 64'(exp_id));
    chk("grant_x", {48'd0, cuvz_x_o}, {48'd0, exp_x});
    repeat (lat) tick();
    chk("write_one_cycle", {63'd0, cuvz_write_o}, 64'd0);
    cuvz_ack_i = 1'b1;
    tick();
    cuvz_ack_i = 1'b0;
    chk("req_ack_own", {62'd0, req_ack_o}, 64'(1 << exp_id));
  endtask

  initial begin
    rst_i       = 1'b1;
    req_write_i = 2'b00;
    req_data_i  = '0;
    cuvz_ack_i  = 1'b0;

    // Reset state
    do_reset();
    chk("rst_ack", {62'd0, req_ack_o}, 64'd0);
    chk("rst_write", {63'd0, cuvz_write_o}, 64'd0);
    chk("rst_x", {48'd0, cuvz_x_o}, 64'd0);
    chk("rst_grant", {62'd0, grant_id_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);

    // Single requester, ack 3 cycles after the write
    req_data_i[63:0] = pack(16'd7, 16'd5, 16'h2000, 16'h4000);
    req_write_i = 2'b01;
    tick();
    chk("t1_write", {63'd0, cuvz_write_o}, 64'd1);
    chk("t1_x", {48'd0, cuvz_x_o}, 64'd5);
    chk("t1_y", {48'd0, cuvz_y_o}, 64'd7);
    chk("t1_f0", {48'd0, cuvz_factor0_o}, 64'h4000);
    chk("t1_f1", {48'd0, cuvz_factor1_o}, 64'h2000);
    chk("t1_busy", {63'd0, busy_o}, 64'd1);
    tick();
    chk("t1_write_drop", {63'd0, cuvz_write_o}, 64'd0);
    tick();
    tick();
    cuvz_ack_i = 1'b1;
    tick();
    cuvz_ack_i  = 1'b0;
    req_write_i = 2'b00;
    chk("t1_req_ack", {62'd0, req_ack_o}, 64'd1);
    tick();
    chk("t1_ack_drop", {62'd0, req_ack_o}, 64'd0);
    chk("t1_idle_busy", {63'd0, busy_o}, 64'd0);
    chk("t1_hold_x", {48'd0, cuvz_x_o}, 64'd5);

    // Round robin with both requesters held for 4 pixels each
    do_reset();
    req_data_i[63:0]   = pack(16'd1, 16'd100, 16'd0, 16'd0);
    req_data_i[127:64] = pack(16'd2, 16'd200, 16'd0, 16'd0);
    req_write_i = 2'b11;
    for (int i = 0; i < 8; i++) begin
      serve(i % 2, 1, (i % 2 == 0) ? 16'd100 : 16'd200);
    end
    req_write_i = 2'b00;
    tick();

    // Spurious acks in IDLE and ISSUE
    do_reset();
    cuvz_ack_i = 1'b1;
    tick();
    cuvz_ack_i = 1'b0;
    chk("sp_idle_ack", {62'd0, req_ack_o}, 64'd0);
    chk("sp_idle_busy", {63'd0, busy_o}, 64'd0);
    req_write_i = 2'b01;
    tick();
    chk("sp_issue", {63'd0, cuvz_write_o}, 64'd1);
    cuvz_ack_i = 1'b1;
    tick();
    cuvz_ack_i = 1'b0;
    chk("sp_issue_ack", {62'd0, req_ack_o}, 64'd0);
    chk("sp_wait_busy", {63'd0, busy_o}, 64'd1);
    tick();
    chk("sp_still_wait", {62'd0, req_ack_o}, 64'd0);
    cuvz_ack_i = 1'b1;
    tick();
    cuvz_ack_i  = 1'b0;
    req_write_i = 2'b00;
    chk("sp_real_ack", {62'd0, req_ack_o}, 64'd1);
    tick();

    // Reset during WAIT
    do_reset();
    req_write_i = 2'b01;
    serve(0, 1, 16'd100);
    req_write_i = 2'b11;
    tick();
    tick();
    chk("rw_grant1", {62'd0, grant_id_o}, 64'd1);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rw_write", {63'd0, cuvz_write_o}, 64'd0);
    chk("rw_x", {48'd0, cuvz_x_o}, 64'd0);
    chk("rw_grant", {62'd0, grant_id_o}, 64'd0);
    chk("rw_busy", {63'd0, busy_o}, 64'd0);
    req_write_i = 2'b00;
    cuvz_ack_i  = 1'b1;
    tick();
    cuvz_ack_i = 1'b0;
    chk("rw_late_ack", {62'd0, req_ack_o}, 64'd0);
    chk("rw_late_busy", {63'd0, busy_o}, 64'd0);
    req_write_i = 2'b11;
    serve(0, 1, 16'd100);
    req_write_i = 2'b10;
    serve(1, 1, 16'd200);
    req_write_i = 2'b00;
    tick();

    // Payload changes while in WAIT
    do_reset();
    req_data_i[63:0] = pack(16'd7, 16'd5, 16'h2000, 16'h4000);
    req_write_i = 2'b01;
    tick();
    req_data_i[63:0] = pack(16'd9, 16'h55, 16'h1, 16'h2);
    tick();
    chk("pl_wait_x", {48'd0, cuvz_x_o}, 64'd5);
    cuvz_ack_i = 1'b1;
    tick();
    cuvz_ack_i  = 1'b0;
    req_write_i = 2'b00;
    chk("pl_done_x", {48'd0, cuvz_x_o}, 64'd5);
    tick();
    chk("pl_idle_x", {48'd0, cuvz_x_o}, 64'd5);

`ifdef GFX_CUVZ_ARB_STATS_EN
    // Statistics: 3 grants to req0, 2 to req1, 2 WAIT cycles each
    do_reset();
    req_data_i[63:0]   = pack(16'd1, 16'd100, 16'd0, 16'd0);
    req_data_i[127:64] = pack(16'd2, 16'd200, 16'd0, 16'd0);
    req_write_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      serve(i % 2, 2, (i % 2 == 0) ? 16'd100 : 16'd200);
    end
    req_write_i = 2'b01;
    serve(0, 2, 16'd100);
    req_write_i = 2'b00;
    tick();
    chk("st_grant0", {32'd0, grant_count_o[31:0]}, 64'd3);
    chk("st_grant1", {32'd0, grant_count_o[63:32]}, 64'd2);
    chk("st_stall", {32'd0, stall_count_o}, 64'd10);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gfx_cuvz_arbiter.md
Name: gfx_cuvz_arbiter

Overview:
Round-robin arbiter that shares one colour/UV/Z interpolation unit between NUM_REQ pixel producers (triangle rasterizer, bezier rasterizer, line walker).
- Accepts level-held pixel requests and picks one winner.
- Latches the winner's payload (x, y, factor0, factor1) and drives a one-cycle write strobe into the interpolator.
- Waits for the interpolator's one-cycle ack, then returns a one-cycle ack to the winning requester.
- Sits between the rasterizer front-ends and the interpolator in the gfx pipeline.

Parameters:
point_width, 16, width of each coordinate and barycentric factor
NUM_REQ, 2, number of requesters (legal range 2..4)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is synchronous and active-high
req_write_i  in  NUM_REQ  per-requester pixel request, held high until that requester's ack
req_data_i  in  NUM_REQ*4*point_width  per-requester payload; slice k = {y, x, factor1, factor0}, factor0 in the LSBs
req_ack_o  out  NUM_REQ  one-cycle completion pulse to the granted requester
cuvz_write_o  out  1  one-cycle write strobe to the interpolator
cuvz_ack_i  in  1  interpolator completion pulse
cuvz_x_o, cuvz_y_o, cuvz_factor0_o, cuvz_factor1_o  out  point_width each  latched winner payload
grant_id_o  out  2  index of the current or last winner
busy_o  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered. Reset values: req_ack_o=0, cuvz_write_o=0, payload outputs=0, grant_id_o=0, busy_o=0, state=IDLE, rr_ptr=0.
- rr_ptr is the index with highest priority.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req_write_i bit is set, pick the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Latch that requester's payload and grant_id_o; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: cuvz_write_o=1 for exactly this one cycle; go to WAIT.
- WAIT:
  - cuvz_write_o=0.
  - When cuvz_ack_i=1, go to DONE and set rr_ptr to grant_id_o+1 (mod NUM_REQ).
- DONE:
  - req_ack_o[grant_id_o]=1 for exactly this one cycle; all other ack bits stay 0.
  - Go to IDLE. Requesters drop or replace req_write_i on the cycle after they see ack.
- Latency: request seen in IDLE at cycle n gives cuvz_write_o high at n+1. Interpolator ack at cycle m gives req_ack_o high at m+1 and IDLE at m+2. Minimum per-pixel overhead is 3 cycles plus interpolator latency.
- Payload outputs stay stable from ISSUE through DONE. They keep their value in IDLE until the next grant.
- cuvz_ack_i is ignored in IDLE, ISSUE and DONE, since a spurious ack is not a completion.
- Requests arriving during ISSUE, WAIT or DONE wait until the next IDLE. A request that drops before being granted is not serviced.
- Simultaneous requests: priority comes only from rr_ptr, so a requester held high is granted within NUM_REQ grants.
- Reset asserted in any state returns to the reset values on the next edge.
  - No ack is issued for an aborted transaction.
  - An interpolator ack arriving after reset is ignored by the IDLE rule.
- req_write_i bits at index >= NUM_REQ do not exist. grant_id_o upper bits are 0 when NUM_REQ=2.

Optional Feature:
GFX_CUVZ_ARB_STATS_EN
- Defined: adds output grant_count_o [NUM_REQ*32-1:0]. Each 32-bit counter increments on its requester's DONE cycle, wraps at 2^32, and is cleared by rst_i.
- Also adds stall_count_o [31:0], which increments on every WAIT cycle and saturates at all-ones.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package gfx_cuvz_arb_pkg holds:
  - state encoding constants (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3);
  - payload field offset constants (factor0 at 0, factor1 at point_width, x at 2*point_width, y at 3*point_width).
- One sub-module, gfx_rr_pick: combinational round-robin selector with inputs req vector and rr_ptr, outputs valid and index. It is reusable by other arbiters in the pipeline.

Test Plan:
- Single requester: req0 with x=5, y=7, f0=0x4000, f1=0x2000; ack_i 3 cycles after the write.
  - Required: cuvz_write_o high exactly 1 cycle at n+1 with the payload on the outputs.
  - Required: req_ack_o=2'b01 one cycle after ack_i.
- Both requesters held high for 4 pixels each after reset: grant order 0,1,0,1,0,1,0,1; each ack reaches only its own requester.
- Spurious cuvz_ack_i pulse in IDLE and in ISSUE: no state change and no req_ack_o; the real ack in WAIT completes normally.
- rst_i asserted during WAIT: all outputs 0 next cycle and rr_ptr=0. A late ack_i produces no req_ack_o. req1 then wins only if req0 is idle.
- Payload change mid-transaction: req0 data modified while in WAIT; cuvz_x_o stays at the latched value.
- STATS_EN build, 3 grants to req0 and 2 to req1 with 2-cycle interpolator latency: grant_count_o={32'd2, 32'd3}, stall_count_o=10.
